fpu_addsub_align: RTL and testbench

- Two-stage pipelined front end for the IEEE-754 single-precision add/sub datapath, directly upstream of the sign-computation stage.
- Unpacks both operands and applies the subtract op to B's sign to form sign_b_eff.
- Compares magnitudes to produce a_is_big, then swaps and right-aligns the smaller significand with guard/round/sticky bits.
- Valid/ready handshake on both sides with full backpressure.

---
 rtl/fpu_pkg.sv | 35 +++
 rtl/fpu_align_shifter.sv | 29 ++
 rtl/fpu_addsub_align.sv | 160 ++++++++++++++++
 tb/tb_fpu_addsub_align.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared definitions for the single-precision add/sub front end.
package fpu_pkg;

    localparam int EXP_W = 8;
    localparam int MAN_W = 23;
    localparam int GRS_W = 3;
    localparam int BIAS  = 127;
    // hidden bit + stored fraction + guard/round/sticky
    localparam int SIG_W = MAN_W + 1 + GRS_W;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] frac;
    } fp32_t;

    // Everything stage 2 needs once big/small have been decided.
    typedef struct packed {
        logic             sign_a;
        logic             sign_b_eff;
        logic             a_is_big;
        logic [EXP_W-1:0] exp_big;
        logic             hidden_big;
        logic [MAN_W-1:0] frac_big;
        logic             hidden_small;
        logic [MAN_W-1:0] frac_small;
        logic [EXP_W-1:0] ediff;
    } align_s1_t;

    // Zeros and subnormals share the exponent of the smallest normal.
    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;
    endfunction

endpackage

// File: rtl/fpu_align_shifter.sv
// Right shift that folds every bit shifted out into bit 0 (sticky).
module fpu_align_shifter #(
    parameter int W   = 27,
    parameter int SHW = 8
) (
    input  logic [W-1:0]   data_i,
    input  logic [SHW-1:0] shamt_i,
    output logic [W-1:0]   data_o
);

    localparam logic [SHW-1:0] W_SH = SHW'(W);

    logic [W-1:0] lost_mask;
    logic [W-1:0] shifted;
    logic         sticky;

    // Shift, collapse lost bits into sticky; huge shifts keep only the sticky.
    always_comb begin
        lost_mask = ~({W{1'b1}} << shamt_i);
        shifted   = data_i >> shamt_i;
        sticky    = |(data_i & lost_mask);
        if (shamt_i >= W_SH) begin
            data_o = {{(W-1){1'b0}}, |data_i};
        end else begin
            data_o = {shifted[W-1:1], shifted[0] | sticky};
        end
    end

endmodule

// File: rtl/fpu_addsub_align.sv
// Two-stage unpack / compare / swap / align front end of the FP32 adder.
// Optional build macro FPU_ALIGN_SPECIAL_EN adds the special[2:0] output
// {any_nan, any_inf, inf_conflict}, registered alongside the data.
// Handshake: a beat moves across a boundary when valid & ready are both high
// on a rising edge; valid never depends on ready, ready is combinational
// from downstream ready (no skid buffer), outputs hold while stalled.
module fpu_addsub_align
    import fpu_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      op_a,
    input  logic [31:0]      op_b,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sign_a,
    output logic             sign_b_eff,
    output logic             a_is_big,
    output logic [EXP_W-1:0] exp_big,
    output logic [SIG_W-1:0] man_big,
    output logic [SIG_W-1:0] man_small
`ifdef FPU_ALIGN_SPECIAL_EN
    ,
    output logic [2:0]       special
`endif
);

    fp32_t            a, b;
    align_s1_t        s1_d, s1_q;
    logic             s1_valid_q, s2_valid_q;
    logic             adv1, adv2;
    logic [EXP_W-1:0] ea, eb;
    logic             a_big;
    logic [SIG_W-1:0] sig_big, sig_small, aligned_small;

    logic             sign_a_q, sign_b_eff_q, a_is_big_q;
    logic [EXP_W-1:0] exp_big_q;
    logic [SIG_W-1:0] man_big_q, man_small_q;

    assign a = op_a;
    assign b = op_b;

    assign adv2      = !s2_valid_q || out_ready;
    assign adv1      = !s1_valid_q || adv2;
    assign in_ready  = adv1;
    assign out_valid = s2_valid_q;

    // Stage 1: unpack, compare raw magnitude fields, swap into big/small.
    always_comb begin
        s1_d            = '0;
        ea              = eff_exp(a.exp);
        eb              = eff_exp(b.exp);
        a_big           = {a.exp, a.frac} >= {b.exp, b.frac};
        s1_d.sign_a     = a.sign;
        s1_d.sign_b_eff = b.sign ^ op_sub;
        s1_d.a_is_big   = a_big;
        if (a_big) begin
            s1_d.exp_big      = ea;
            s1_d.hidden_big   = |a.exp;
            s1_d.frac_big     = a.frac;
            s1_d.hidden_small = |b.exp;
            s1_d.frac_small   = b.frac;
            s1_d.ediff        = ea - eb;
        end else begin
            s1_d.exp_big      = eb;
            s1_d.hidden_big   = |b.exp;
            s1_d.frac_big     = b.frac;
            s1_d.hidden_small = |a.exp;
            s1_d.frac_small   = a.frac;
            s1_d.ediff        = eb - ea;
        end
    end

    // Stage-1 pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
        end else if (adv1) begin
            s1_valid_q <= in_valid;
            s1_q       <= s1_d;
        end
    end

    // Stage 2: build full significands and align the smaller one.
    always_comb begin
        sig_big   = {s1_q.hidden_big, s1_q.frac_big, {GRS_W{1'b0}}};
        sig_small = {s1_q.hidden_small, s1_q.frac_small, {GRS_W{1'b0}}};
    end

    fpu_align_shifter #(
        .W   (SIG_W),
        .SHW (EXP_W)
    ) u_shifter (
        .data_i  (sig_small),
        .shamt_i (s1_q.ediff),
        .data_o  (aligned_small)
    );

    // Stage-2 (output) register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q   <= 1'b0;
            sign_a_q     <= 1'b0;
            sign_b_eff_q <= 1'b0;
            a_is_big_q   <= 1'b0;
            exp_big_q    <= '0;
            man_big_q    <= '0;
            man_small_q  <= '0;
        end else if (adv2) begin
            s2_valid_q   <= s1_valid_q;
            sign_a_q     <= s1_q.sign_a;
            sign_b_eff_q <= s1_q.sign_b_eff;
            a_is_big_q   <= s1_q.a_is_big;
            exp_big_q    <= s1_q.exp_big;
            man_big_q    <= sig_big;
            man_small_q  <= aligned_small;
        end
    end

    assign sign_a     = sign_a_q;
    assign sign_b_eff = sign_b_eff_q;
    assign a_is_big   = a_is_big_q;
    assign exp_big    = exp_big_q;
    assign man_big    = man_big_q;
    assign man_small  = man_small_q;

`ifdef FPU_ALIGN_SPECIAL_EN
    logic [2:0] special_s1_d, special_s1_q, special_q;
    logic       a_inf, b_inf, a_nan, b_nan;

    // Classify operands as NaN / Inf and flag Inf - Inf.
    always_comb begin
        a_inf        = (a.exp == '1) && (a.frac == '0);
        b_inf        = (b.exp == '1) && (b.frac == '0);
        a_nan        = (a.exp == '1) && (a.frac != '0);
        b_nan        = (b.exp == '1) && (b.frac != '0);
        special_s1_d = {a_nan || b_nan,
                        a_inf || b_inf,
                        a_inf && b_inf && (a.sign != (b.sign ^ op_sub))};
    end

    // Carry the special flags through both stages with the data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            special_s1_q <= '0;
            special_q    <= '0;
        end else begin
            if (adv1) special_s1_q <= special_s1_d;
            if (adv2) special_q    <= special_s1_q;
        end
    end

    assign special = special_q;
`endif

endmodule

// File: tb/tb_fpu_addsub_align.sv
// Self-checking bench for fpu_addsub_align: directed vectors, stall and reset
// scenarios, then randomized traffic checked against a reference model.
module tb_fpu_addsub_align;
    import fpu_pkg::*;

`ifdef FPU_ALIGN_SPECIAL_EN
    localparam int SB_W = 3 + EXP_W + 2*SIG_W + 3;
`else
    localparam int SB_W = 3 + EXP_W + 2*SIG_W;
`endif

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      op_a;
    logic [31:0]      op_b;
    logic             op_sub;
    logic             out_valid;
    logic             out_ready;
    logic             sign_a;
    logic             sign_b_eff;
    logic             a_is_big;
    logic [EXP_W-1:0] exp_big;
    logic [SIG_W-1:0] man_big;
    logic [SIG_W-1:0] man_small;
`ifdef FPU_ALIGN_SPECIAL_EN
    logic [2:0]       special;
`endif

    int checks   = 0;
    int failures = 0;
    int n_out    = 0;
    logic rand_rdy = 1'b0;
    logic [SB_W-1:0] exp_q[$];

    fpu_addsub_align dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_sub     (op_sub),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .sign_a     (sign_a),
        .sign_b_eff (sign_b_eff),
        .a_is_big   (a_is_big),
        .exp_big    (exp_big),
        .man_big    (man_big),
        .man_small  (man_small)
`ifdef FPU_ALIGN_SPECIAL_EN
        ,
        .special    (special)
`endif
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [SB_W-1:0] ref_model(input logic [31:0] a, input logic [31:0] b,
                                                  input logic sub);
        logic [31:0] big, sml;
        logic        aib, sbe;
        longint      big_e, sml_e, full_big, full_sml, d, p, q, r, sml_out;
        logic [SB_W-1:0] res;
        sbe = b[31] ^ sub;
        aib = longint'(a[30:0]) >= longint'(b[30:0]);
        big = aib ? a : b;
        sml = aib ? b : a;
        big_e = (big[30:23] == 0) ? 1 : longint'(big[30:23]);
        sml_e = (sml[30:23] == 0) ? 1 : longint'(sml[30:23]);
        full_big = ((big[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(big[22:0]);
        full_sml = ((sml[30:23] != 0) ? 64'd8388608 : 64'd0) + longint'(sml[22:0]);
        full_big = full_big * 8;
        full_sml = full_sml * 8;
        d = big_e - sml_e;
        if (d >= 27) begin
            sml_out = (full_sml != 0) ? 1 : 0;
        end else begin
            p = longint'(1) << d;
            q = full_sml / p;
            r = full_sml % p;
            sml_out = q | ((r != 0) ? 1 : 0);
        end
        res = '0;
        res[SB_W-1 -: 3+EXP_W+2*SIG_W] = {a[31], sbe, aib, big_e[EXP_W-1:0],
                                          full_big[SIG_W-1:0], sml_out[SIG_W-1:0]};
`ifdef FPU_ALIGN_SPECIAL_EN
        begin
            logic an, bn, ai, bi;
            an = (a[30:23] == 8'hFF) && (a[22:0] != 0);
            bn = (b[30:23] == 8'hFF) && (b[22:0] != 0);
            ai = (a[30:23] == 8'hFF) && (a[22:0] == 0);
            bi = (b[30:23] == 8'hFF) && (b[22:0] == 0);
            res[2:0] = {an || bn, ai || bi, ai && bi && (a[31] != sbe)};
        end
`endif
        return res;
    endfunction

    function automatic logic [SB_W-1:0] obs_vec();
        logic [SB_W-1:0] v;
        v = '0;
        v[SB_W-1 -: 3+EXP_W+2*SIG_W] = {sign_a, sign_b_eff, a_is_big, exp_big, man_big, man_small};
`ifdef FPU_ALIGN_SPECIAL_EN
        v[2:0] = special;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [SB_W-1:0] e, o;
        if (rst_n === 1'b1) begin
            if (in_valid && in_ready) exp_q.push_back(ref_model(op_a, op_b, op_sub));
            if (out_valid && out_ready) begin
                o = obs_vec();
                n_out++;
                checks++;
                assert (exp_q.size() != 0) else begin
                    failures++;
                    $error("FAIL sb_unexpected observed=%h expected=none", o);
                end
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checks++;
                    assert (o === e) else begin
                        failures++;
                        $error("FAIL sb_data observed=%h expected=%h", o, e);
                    end
                end
            end
        end
    end

    // Random downstream backpressure during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 after the beat was accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op_a = a;
        op_b = b;
        op_sub = sub;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        chk("send_timeout", 68'(ok), 68'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Returns at the negedge where out_valid is first seen; reports cycles waited.
    task automatic wait_out(output int waited);
        logic ok;
        ok = 1'b0;
        waited = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            waited++;
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        chk("out_timeout", 68'(ok), 68'(1));
    endtask

    task automatic direct(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic e_sa, input logic e_sbe,
                          input logic e_aib, input logic [7:0] e_exp,
                          input logic [26:0] e_mb, input logic [26:0] e_ms);
        int waited;
        send(a, b, sub);
        wait_out(waited);
        chk({tag, "_latency"}, 68'(waited), 68'(2));
        chk({tag, "_flags"}, 68'({sign_a, sign_b_eff, a_is_big}), 68'({e_sa, e_sbe, e_aib}));
        chk({tag, "_exp_big"}, 68'(exp_big), 68'(e_exp));
        chk({tag, "_man_big"}, 68'(man_big), 68'(e_mb));
        chk({tag, "_man_small"}, 68'(man_small), 68'(e_ms));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        chk(tag, 68'(exp_q.size()), 68'(0));
    endtask

    function automatic logic [31:0] rand_op(input int e);
        logic [7:0] ee;
        ee = 8'(e);
        return {1'($urandom_range(0, 1)), ee,
                ($urandom_range(0, 3) == 0) ? 23'd0 : 23'($urandom)};
    endfunction

    // ---------------- directed + random sequence ----------------
    initial begin
        logic [SB_W-1:0] snap;
        int n_before, ea, eb;

        rst_n = 1'b0;
        in_valid = 1'b0;
        op_a = '0;
        op_b = '0;
        op_sub = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", 68'(out_valid), 68'(0));
        chk("reset_data", 68'(obs_vec()), 68'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_reset_in_ready", 68'(in_ready), 68'(1));
        out_ready = 1'b1;

        // Directed vectors: unity add, subtract, swap, far alignment, zeros, Inf.
        direct("one_plus_one", 32'h3F800000, 32'h3F800000, 1'b0,
               1'b0, 1'b0, 1'b1, 8'(BIAS), 27'h4000000, 27'h4000000);
        direct("one_minus_half", 32'h3F800000, 32'h3F000000, 1'b1,
               1'b0, 1'b1, 1'b1, 8'h7F, 27'h4000000, 27'h2000000);
        direct("half_plus_negone", 32'h3F000000, 32'hBF800000, 1'b0,
               1'b0, 1'b1, 1'b0, 8'h7F, 27'h4000000, 27'h2000000);
        direct("ediff24_sticky", 32'h4B800000, 32'h3F800001, 1'b0,
               1'b0, 1'b0, 1'b1, 8'h97, 27'h4000000, 27'h0000005);
        direct("subnormal_far", 32'h4B800000, 32'h00000001, 1'b0,
               1'b0, 1'b0, 1'b1, 8'h97, 27'h4000000, 27'h0000001);
        direct("both_zero", 32'h00000000, 32'h00000000, 1'b0,
               1'b0, 1'b0, 1'b1, 8'h01, 27'h0, 27'h0);
        direct("inf_minus_inf", 32'h7F800000, 32'hFF800000, 1'b0,
               1'b0, 1'b1, 1'b1, 8'hFF, 27'h4000000, 27'h4000000);
        direct("neg_a_sub", 32'hC0400000, 32'h40800000, 1'b1,
               1'b1, 1'b1, 1'b0, 8'h81, 27'h4000000, 27'h3000000);

        // Stall: two beats fill the pipe, the third is refused until release.
        n_before = n_out;
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3E800000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b1);
        in_valid = 1'b1;
        op_a = 32'h41200000;
        op_b = 32'hC1200000;
        op_sub = 1'b0;
        @(negedge clk);
        snap = obs_vec();
        for (int i = 0; i < 4; i++) begin
            chk("stall_in_ready", 68'(in_ready), 68'(0));
            chk("stall_out_valid", 68'(out_valid), 68'(1));
            chk("stall_hold", 68'(obs_vec()), 68'(snap));
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (in_ready) break;
        end
        chk("stall_release_accept", 68'(in_ready), 68'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("stall_drain");
        repeat (2) @(negedge clk);
        chk("stall_count", 68'(n_out - n_before), 68'(3));
        @(posedge clk);
        #1;

        // Reset with both stages full.
        out_ready = 1'b0;
        send(32'h3F800000, 32'h3F800000, 1'b0);
        send(32'h40400000, 32'h3F000000, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_out_valid", 68'(out_valid), 68'(0));
        chk("midreset_in_ready", 68'(in_ready), 68'(1));
        exp_q.delete();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        n_before = n_out;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("after_reset_idle", 68'({out_valid, in_ready}), 68'({1'b0, 1'b1}));
        end
        @(posedge clk);
        #1;

        // Random traffic with random backpressure.
        rand_rdy = 1'b1;
        for (int t = 0; t < 300; t++) begin
            ea = $urandom_range(0, 255);
            case ($urandom_range(0, 3))
                0: eb = $urandom_range(0, 255);
                1: eb = ea;
                default: eb = ea + $urandom_range(0, 60) - 30;
            endcase
            if (eb < 0) eb = 0;
            if (eb > 255) eb = 255;
            send(rand_op(ea), rand_op(eb), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_rdy = 1'b0;
        #2;
        out_ready = 1'b1;
        drain("random_drain");
        chk("random_outputs_seen", 68'(n_out - n_before > 250), 68'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "global timeout");
    end

endmodule
